// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, handshakes with instruction memory, issues one word to decode and
// applies beq/bne/jump on decode_ack. Optional macro FETCH_TIMEOUT_EN adds a fetch wait limit.
module instr_fetch_unit #(
   parameter int unsigned          PC_WIDTH       = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_PC       = 32'h0000_0000,
   parameter int unsigned          TIMEOUT_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [31:0]         imem_rdata,
   input  logic                imem_ready,
   output logic [31:0]         instr_out,
   output logic [5:0]          opcode,
   output logic                instr_valid,
   input  logic                decode_ack,
   input  logic                beq,
   input  logic                bne,
   input  logic                jump,
   input  logic                zero,
   input  logic [15:0]         branch_imm,
   input  logic [25:0]         jump_target,
   output logic [PC_WIDTH-1:0] pc,
   output logic [31:0]         instr_count,
   output logic                fetch_err
);

   typedef enum logic [1:0] {IDLE = 2'b00, FETCH = 2'b01, ISSUE = 2'b10} state_t;

   state_t              state_r;
   state_t              state_s;
   logic [PC_WIDTH-1:0] pc_r;
   logic [PC_WIDTH-1:0] next_pc_s;
   logic [31:0]         instr_r;
   logic [31:0]         count_r;
   logic                timeout_s;

   // Priority jump > beq > bne; all arithmetic wraps at the PC width.
   function automatic logic [PC_WIDTH-1:0] calc_next_pc(
      input logic [PC_WIDTH-1:0] cur,
      input logic                j,
      input logic                b_eq,
      input logic                b_ne,
      input logic                z,
      input logic [15:0]         imm,
      input logic [25:0]         tgt
   );
      logic [PC_WIDTH-1:0] pc4;
      logic [PC_WIDTH-1:0] boff;
      pc4  = cur + PC_WIDTH'(32'd4);
      boff = {{(PC_WIDTH-18){imm[15]}}, imm, 2'b00};
      if (j) begin
         return {pc4[PC_WIDTH-1 -: 4], tgt, 2'b00};
      end else if ((b_eq && z) || (b_ne && !z)) begin
         return pc4 + boff;
      end else begin
         return pc4;
      end
   endfunction

   assign next_pc_s = calc_next_pc(pc_r, jump, beq, bne, zero, branch_imm, jump_target);

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            state_s = FETCH;
         end
         FETCH: begin
            if (imem_ready) begin
               state_s = ISSUE;
            end else if (timeout_s) begin
               state_s = IDLE;
            end else begin
               state_s = FETCH;
            end
         end
         ISSUE: begin
            if (decode_ack) begin
               state_s = FETCH;
            end else begin
               state_s = ISSUE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, PC, held instruction and retire counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         pc_r    <= RESET_PC;
         instr_r <= 32'h0000_0000;
         count_r <= 32'h0000_0000;
      end else begin
         state_r <= state_s;
         if ((state_r == FETCH) && imem_ready) begin
            instr_r <= imem_rdata;
         end
         if ((state_r == ISSUE) && decode_ack) begin
            pc_r    <= next_pc_s;
            count_r <= count_r + 32'd1;
         end
      end
   end

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [WAIT_W-1:0] wait_r;
   logic              err_r;

   // imem_ready on the terminal-count cycle wins over the timeout.
   assign timeout_s = (state_r == FETCH) && !imem_ready &&
                      (wait_r == WAIT_W'(TIMEOUT_CYCLES - 32'd1));

   // Fetch wait counter and one-cycle error pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_r <= '0;
         err_r  <= 1'b0;
      end else begin
         err_r <= timeout_s;
         if ((state_r == FETCH) && !imem_ready && !timeout_s) begin
            wait_r <= wait_r + WAIT_W'(1);
         end else begin
            wait_r <= '0;
         end
      end
   end

   assign fetch_err = err_r;
`else
   assign timeout_s = 1'b0;
   assign fetch_err = 1'b0;
`endif

   assign imem_req    = (state_r == FETCH);
   assign instr_valid = (state_r == ISSUE);
   assign imem_addr   = pc_r;
   assign pc          = pc_r;
   assign instr_out   = instr_r;
   assign opcode      = instr_r[31:26];
   assign instr_count = count_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle model of the fetch/issue protocol checked every cycle,
// plus directed instructions with hand-computed next-PC values.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam int          TO_CYC = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0000_0000;
   logic        imem_ready = 1'b0;
   logic [31:0] instr_out;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic        decode_ack = 1'b0;
   logic        beq = 1'b0;
   logic        bne = 1'b0;
   logic        jump = 1'b0;
   logic        zero = 1'b0;
   logic [15:0] branch_imm = 16'h0000;
   logic [25:0] jump_target = 26'h0;
   logic [31:0] pc;
   logic [31:0] instr_count;
   logic        fetch_err;

   instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instr_out(instr_out),
      .opcode(opcode), .instr_valid(instr_valid), .decode_ack(decode_ack),
      .beq(beq), .bne(bne), .jump(jump), .zero(zero), .branch_imm(branch_imm),
      .jump_target(jump_target), .pc(pc), .instr_count(instr_count), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model phases: 0 = waiting to request, 1 = requesting, 2 = holding for decode
   int          ph = 0;
   int          m_wait = 0;
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_instr = 32'h0;
   logic [31:0] m_cnt = 32'h0;
   logic        m_err = 1'b0;
   bit          chk_en = 1'b0;

   function automatic logic [31:0] model_next(input logic [31:0] p, input logic j, input logic b,
                                             input logic bn, input logic z,
                                             input logic [15:0] imm, input logic [25:0] tgt);
      logic [31:0] p4;
      int          off;
      p4  = p + 32'd4;
      off = int'($signed(imm)) * 4;
      if (j) return (p4 & 32'hF000_0000) | ({6'd0, tgt} << 2);
      if ((b && z) || (bn && !z)) return p4 + 32'(off);
      return p4;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         ph <= 0; m_wait <= 0; m_pc <= RST_PC; m_instr <= 32'h0; m_cnt <= 32'h0;
         m_err <= 1'b0; chk_en <= 1'b1;
      end else begin
         m_err <= 1'b0;
         if (ph == 0) begin
            ph <= 1; m_wait <= 0;
         end else if (ph == 1) begin
            if (imem_ready) begin
               m_instr <= imem_rdata; ph <= 2;
`ifdef FETCH_TIMEOUT_EN
            end else if (m_wait == TO_CYC - 1) begin
               m_err <= 1'b1; ph <= 0; m_wait <= 0;
`endif
            end else begin
               m_wait <= m_wait + 1;
            end
         end else if (decode_ack) begin
            m_pc  <= model_next(m_pc, jump, beq, bne, zero, branch_imm, jump_target);
            m_cnt <= m_cnt + 32'd1;
            ph    <= 1; m_wait <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_req", {31'd0, imem_req}, {31'd0, ph == 1});
         chk("instr_valid", {31'd0, instr_valid}, {31'd0, ph == 2});
         chk("imem_addr", imem_addr, m_pc);
         chk("pc", pc, m_pc);
         chk("instr_out", instr_out, m_instr);
         chk("opcode", {26'd0, opcode}, {26'd0, m_instr[31:26]});
         chk("instr_count", instr_count, m_cnt);
         chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 40) begin
         step();
         n++;
      end
      chk("wait_req", {31'd0, imem_req}, 32'd1);
   endtask

   task automatic do_instr(input logic [31:0] w, input logic [5:0] exp_op, input int stall,
                           input logic j, input logic b, input logic bn, input logic z,
                           input logic [15:0] imm, input logic [25:0] tgt,
                           input logic [31:0] exp_pc);
      wait_req();
      imem_rdata = w; imem_ready = 1'b1;
      step();
      imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      chk("issue_opcode", {26'd0, opcode}, {26'd0, exp_op});
      jump = j; beq = b; bne = bn; zero = z; branch_imm = imm; jump_target = tgt;
      for (int i = 0; i < stall; i++) step();
      if (stall > 0) begin
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
         chk("stall_instr", instr_out, w);
      end
      decode_ack = 1'b1;
      step();
      decode_ack = 1'b0; jump = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0;
      chk("next_pc", pc, exp_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int errs_seen;
      int req_low;
      repeat (3) step();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_pc", pc, 32'h0040_0000);
      chk("rst_instr", instr_out, 32'h0);
      chk("rst_count", instr_count, 32'h0);
      chk("rst_err", {31'd0, fetch_err}, 32'd0);
      reset = 1'b0;
      step();
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0040_0000);

      c0 = cyc;
      do_instr(32'h8C01_0000, 6'h23, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0040_0004);
      do_instr(32'h0022_1820, 6'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0040_0008);
      chk("count_2", instr_count, 32'd2);
      chk("throughput_cycles", 32'(cyc - c0), 32'd4);
      do_instr(32'h0000_0000, 6'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0040_000C);
      do_instr(32'h0000_0000, 6'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0040_0010);
      do_instr(32'h1000_FFFF, 6'h04, 0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 26'h0, 32'h0040_0010);
      do_instr(32'h1000_FFFF, 6'h04, 0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 26'h0, 32'h0040_0014);
      do_instr(32'h0000_0000, 6'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0040_0018);
      do_instr(32'h0000_0000, 6'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0040_001C);
      do_instr(32'h0000_0000, 6'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0040_0020);
      do_instr(32'h0810_0004, 6'h02, 0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0, 26'h010_0004, 32'h0040_0010);
      do_instr(32'h0800_0000, 6'h02, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_0000);
      do_instr(32'h1400_0003, 6'h05, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 26'h0, 32'h0000_0010);
      do_instr(32'h1400_0003, 6'h05, 0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 26'h0, 32'h0000_0014);
      do_instr(32'h0800_0000, 6'h02, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_0000);
      do_instr(32'h1000_FFFE, 6'h04, 0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE, 26'h0, 32'hFFFF_FFFC);
      do_instr(32'h2042_0001, 6'h08, 5, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_0000);

      // Memory never answers; stray decode_ack during FETCH must be ignored.
      errs_seen = 0; req_low = 0;
      decode_ack = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (fetch_err) errs_seen++;
         if (!imem_req) req_low++;
      end
      decode_ack = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      chk("timeout_pulses", 32'(errs_seen), 32'd1);
      chk("timeout_req_low", 32'(req_low), 32'd1);
`else
      chk("timeout_pulses", 32'(errs_seen), 32'd0);
      chk("timeout_req_low", 32'(req_low), 32'd0);
`endif
      chk("refetch_addr", imem_addr, 32'h0000_0000);
      do_instr(32'h0000_0000, 6'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_0004);

      // Reset while an instruction is held, with a late imem_ready.
      do_instr(32'h0000_0000, 6'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_0008);
      wait_req();
      imem_rdata = 32'h8C01_0000; imem_ready = 1'b1;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0; imem_ready = 1'b0;
      chk("midrst_pc", pc, 32'h0040_0000);
      chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
      chk("midrst_count", instr_count, 32'd0);
      chk("midrst_instr", instr_out, 32'h0);
      step();
      chk("midrst_req", {31'd0, imem_req}, 32'd1);
      do_instr(32'h0022_1820, 6'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0040_0004);
      chk("final_count", instr_count, 32'd1);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
